// File: rtl/skew_ififo_pkg.sv
// skew_ififo_pkg -- shared constants for the skewed input FIFO.
//   Default geometry (COL/BW/DEPTH), rd_config mode encodings and o_err bit
//   positions. Imported by skew_ififo and col_fifo.
package skew_ififo_pkg;
  localparam int COL_DEF   = 8;
  localparam int BW_DEF    = 4;
  localparam int DEPTH_DEF = 16;

  typedef enum logic {
    MODE_STAGGER = 1'b0,
    MODE_BCAST   = 1'b1
  } rd_mode_e;

  localparam int ERR_OVF = 0;  // write dropped on a full column
  localparam int ERR_UNF = 1;  // pop ignored on an empty column
endpackage

// File: rtl/skew_ififo_col_fifo.sv
// col_fifo -- one column of the skewed input FIFO.
//   First-word fall-through circular buffer, DEPTH entries of BW bits.
//   Ports: clk, reset (sync, active high), wr/rd requests, in (write data),
//   out (head entry, 0 when empty), o_empty, o_full.
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
module col_fifo
  import skew_ififo_pkg::*;
#(
  parameter int BW    = BW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd,
  input  logic [BW-1:0] in,
  output logic [BW-1:0] out,
  output logic          o_empty,
  output logic          o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wptr, rptr;
  logic [BW-1:0] mem [DEPTH];
  logic          do_wr, do_rd;

  assign o_empty = (wptr == rptr);
  assign o_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // Both qualifiers use pre-edge status: on a full column a concurrent
  // write is dropped, on an empty column a concurrent pop is ignored.
  assign do_wr = wr && !o_full;
  assign do_rd = rd && !o_empty;

  // Pointers wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

  // Storage is never cleared; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (do_wr && !reset) mem[wptr[AW-1:0]] <= in;
  end

  assign out = o_empty ? '0 : mem[rptr[AW-1:0]];
endmodule

// File: rtl/skew_ififo.sv
// skew_ififo -- COL independent column FIFOs with a shared read-enable
// register that either pops all columns together (broadcast) or walks a
// single read pulse across the columns one cycle apart (staggered).
//   Ports: clk, reset (sync, active high), in/wr (per-column write data and
//   request), rd (read request), rd_config (1 broadcast, 0 staggered),
//   out (per-column head entry), o_full/o_ready/o_valid (aggregate status),
//   o_rd_busy (any read enable pending), o_err (sticky overflow/underflow).
//   Optional macro SKEW_IFIFO_ERR_EN enables the sticky error flags; without
//   it o_err is tied to zero.
module skew_ififo
  import skew_ififo_pkg::*;
#(
  parameter int COL   = COL_DEF,
  parameter int BW    = BW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COL*BW-1:0] in,
  input  logic [COL-1:0]    wr,
  input  logic              rd,
  input  logic              rd_config,
  output logic [COL*BW-1:0] out,
  output logic              o_full,
  output logic              o_ready,
  output logic              o_valid,
  output logic              o_rd_busy,
  output logic [1:0]        o_err
);
  logic [COL-1:0] rd_en;
  logic [COL-1:0] full, empty;

  // Broadcast overwrites any in-flight stagger pattern; stagger shifts the
  // request in at column 0 so column k pops k+1 edges after rd is sampled.
  always_ff @(posedge clk) begin
    if (reset)
      rd_en <= '0;
    else if (rd_mode_e'(rd_config) == MODE_BCAST)
      rd_en <= {COL{rd}};
    else
      rd_en <= {rd_en[COL-2:0], rd};
  end

  for (genvar i = 0; i < COL; i++) begin : g_col
    col_fifo #(.BW(BW), .DEPTH(DEPTH)) u_col (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr[i]),
      .rd      (rd_en[i]),
      .in      (in[i*BW +: BW]),
      .out     (out[i*BW +: BW]),
      .o_empty (empty[i]),
      .o_full  (full[i])
    );
  end

  assign o_full    = &full;
  assign o_ready   = ~|full;
  assign o_valid   = ~|empty;
  assign o_rd_busy = |rd_en;

`ifdef SKEW_IFIFO_ERR_EN
  logic [1:0] err;

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= '0;
    end else begin
      if (|(wr & full))     err[ERR_OVF] <= 1'b1;
      if (|(rd_en & empty)) err[ERR_UNF] <= 1'b1;
    end
  end

  assign o_err = err;
`else
  assign o_err = 2'b00;
`endif
endmodule

// File: tb/tb_skew_ififo.sv
// tb_skew_ififo -- directed self-checking bench for skew_ififo at
// COL=8, BW=4, DEPTH=16. Inputs change 1 time unit after each rising edge
// and outputs are sampled there, away from the active edge.
module tb_skew_ififo;
  localparam int COL = 8, BW = 4, DEPTH = 16;
`ifdef SKEW_IFIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [COL*BW-1:0] din = '0;
  logic [COL-1:0]    wr = '0;
  logic              rd = 1'b0;
  logic              rd_config = 1'b0;
  logic [COL*BW-1:0] out;
  logic              o_full, o_ready, o_valid, o_rd_busy;
  logic [1:0]        o_err;

  int checks = 0;
  int errors = 0;

  skew_ififo #(.COL(COL), .BW(BW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in(din), .wr(wr), .rd(rd), .rd_config(rd_config),
    .out(out), .o_full(o_full), .o_ready(o_ready), .o_valid(o_valid),
    .o_rd_busy(o_rd_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr = 8'hFF; rd = 1'b1;
    tick();
    reset = 1'b0; wr = '0; rd = 1'b0;
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset_out got %h exp 00000000", out); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ready); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", o_full); end
    checks++; if (o_rd_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_rd_busy); end
    checks++; if (o_err !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", o_err); end
  endtask

  task automatic test_fill();
    logic [3:0] c4;
    for (int c = 0; c < DEPTH; c++) begin
      c4 = 4'(c);
      wr = 8'hFF; din = {COL{c4}};
      tick();
    end
    wr = '0;
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", o_full); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", o_ready); end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL fill_valid got %b exp 1", o_valid); end
    checks++; if (o_err !== 2'b00) begin errors++; $display("FAIL fill_err_early got %b exp 00", o_err); end
    // 17th write is dropped: head and flags unchanged
    wr = 8'hFF; din = 32'hFFFF_FFFF;
    tick();
    wr = '0;
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL overflow_out got %h exp 00000000", out); end
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL overflow_full got %b exp 1", o_full); end
    checks++; if (o_err !== {1'b0, ERR_EN}) begin errors++; $display("FAIL overflow_err got %b exp %b", o_err, {1'b0, ERR_EN}); end
  endtask

  task automatic test_bcast();
    rd_config = 1'b1; rd = 1'b1;
    tick();  // E0
    rd = 1'b0;
    checks++; if (o_rd_busy !== 1'b1) begin errors++; $display("FAIL bcast_busy_e0 got %b exp 1", o_rd_busy); end
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL bcast_out_e0 got %h exp 00000000", out); end
    tick();  // E1
    checks++; if (out !== 32'h1111_1111) begin errors++; $display("FAIL bcast_out_e1 got %h exp 11111111", out); end
    checks++; if (o_rd_busy !== 1'b0) begin errors++; $display("FAIL bcast_busy_e1 got %b exp 0", o_rd_busy); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bcast_ready got %b exp 1", o_ready); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL bcast_full got %b exp 0", o_full); end
  endtask

  task automatic test_stagger();
    int busy_cycles = 0;
    rd_config = 1'b0; rd = 1'b1;
    tick();  // E0
    rd = 1'b0;
    for (int k = 0; k < COL; k++) begin
      if (o_rd_busy === 1'b1) busy_cycles++;
      if (k == 4) begin
        checks++; if (out !== 32'h1111_2222) begin errors++; $display("FAIL stagger_mid_out got %h exp 11112222", out); end
      end
      tick();
    end
    checks++; if (busy_cycles != 8) begin errors++; $display("FAIL stagger_busy_cycles got %0d exp 8", busy_cycles); end
    checks++; if (o_rd_busy !== 1'b0) begin errors++; $display("FAIL stagger_busy_end got %b exp 0", o_rd_busy); end
    checks++; if (out !== 32'h2222_2222) begin errors++; $display("FAIL stagger_out got %h exp 22222222", out); end
  endtask

  task automatic test_full_col_pop_push();
    // column 3 holds 14 entries; top it up to 16
    wr = 8'h08; din = {COL{4'hA}};
    tick();
    din = {COL{4'hB}};
    tick();
    wr = '0;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL col3_full_ready got %b exp 0", o_ready); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL col3_full_allfull got %b exp 0", o_full); end
    rd_config = 1'b1; rd = 1'b1;
    tick();  // E0
    rd = 1'b0; wr = 8'h08; din = {COL{4'hC}};
    tick();  // E1: pop and write on full col 3
    wr = '0;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL col3_popwr_ready got %b exp 1", o_ready); end
    checks++; if (out !== 32'h3333_3333) begin errors++; $display("FAIL col3_popwr_out got %h exp 33333333", out); end
    wr = 8'h08; din = {COL{4'hD}};
    tick();
    wr = '0;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL col3_refill_ready got %b exp 0", o_ready); end
  endtask

  task automatic test_empty_col_pop_push();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (o_err !== 2'b00) begin errors++; $display("FAIL empty_err_clr got %b exp 00", o_err); end
    rd_config = 1'b1; rd = 1'b1;
    tick();  // E0
    rd = 1'b0; wr = 8'h01; din = {COL{4'h5}};
    tick();  // E1: pop and write on empty col 0
    wr = '0;
    checks++; if (out !== 32'h0000_0005) begin errors++; $display("FAIL empty_popwr_out got %h exp 00000005", out); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL empty_popwr_valid got %b exp 0", o_valid); end
    checks++; if (o_err !== {ERR_EN, 1'b0}) begin errors++; $display("FAIL underflow_err got %b exp %b", o_err, {ERR_EN, 1'b0}); end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    tick();
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL empty_occ1_out got %h exp 00000000", out); end
  endtask

  task automatic test_wrap();
    logic [3:0] k4;
    rd_config = 1'b1;
    for (int k = 0; k < 40; k++) begin
      k4 = 4'(k);
      wr = 8'h01; rd = 1'b1; din = {28'h0, k4};
      tick();
      checks++; if (out !== {28'h0, k4}) begin errors++; $display("FAIL wrap_%0d got %h exp %h", k, out, {28'h0, k4}); end
    end
    wr = '0; rd = 1'b0;
    tick();
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL wrap_drain got %h exp 00000000", out); end
  endtask

  task automatic test_reset_mid_stagger();
    rd_config = 1'b0; wr = 8'hFF; din = 32'h9999_9999; rd = 1'b1;
    tick();
    wr = '0;
    tick();
    tick();  // rd_en = 0000_0111
    checks++; if (o_rd_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", o_rd_busy); end
    checks++; if (out !== 32'h9999_9900) begin errors++; $display("FAIL mid_out got %h exp 99999900", out); end
    reset = 1'b1; wr = 8'hFF;
    tick();
    reset = 1'b0; wr = '0; rd = 1'b0;
    checks++; if (o_rd_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", o_rd_busy); end
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL rst_mid_out got %h exp 00000000", out); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b exp 1", o_ready); end
    checks++; if (o_err !== 2'b00) begin errors++; $display("FAIL rst_mid_err got %b exp 00", o_err); end
    tick();
    checks++; if (o_rd_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy2 got %b exp 0", o_rd_busy); end
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL rst_mid_out2 got %h exp 00000000", out); end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill();
    test_bcast();
    test_stagger();
    test_full_col_pop_push();
    test_empty_col_pop_push();
    test_wrap();
    test_reset_mid_stagger();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
